csr_trap_ctrl: RTL and testbench

//  Owns the single CSR write/read port in front of csr; arbitrates instruction CSR traffic
//  (csrrw/csrrs/csrrc) against trap-entry (ecall/ebreak/exception) and mret sequences.

---
 rtl/csr_trap_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: owns the single CSR write/read port in front of the CSR file.
// Arbitrates instruction CSR traffic against trap-entry (MEPC, MCAUSE, MSTATUS
// written one per cycle, then redirect to MTVEC) and mret (MSTATUS rewrite,
// then redirect to MEPC). M-mode only.
// Optional feature: define MTVEC_VECTORED_EN to honour vectored MTVEC mode for
// interrupts; when undefined the MTVEC mode bits are ignored and every trap
// redirects to the direct base.
module csr_trap_ctrl #(
    parameter int unsigned CSR_ADDR_WIDTH = 12,
    parameter int unsigned CSR_DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inst_csr_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0] inst_csr_waddr_i,
    input  logic [CSR_DATA_WIDTH-1:0] inst_csr_wdata_i,
    input  logic [CSR_ADDR_WIDTH-1:0] inst_csr_raddr_i,
    output logic [CSR_DATA_WIDTH-1:0] inst_csr_rdata_o,
    input  logic                      trap_valid_i,
    input  logic [CSR_DATA_WIDTH-1:0] trap_cause_i,
    input  logic [CSR_DATA_WIDTH-1:0] trap_pc_i,
    input  logic                      mret_valid_i,
    output logic                      busy_o,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [CSR_DATA_WIDTH-1:0] csr_wdata_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_raddr_o,
    input  logic [CSR_DATA_WIDTH-1:0] csr_rdata_i,
    input  logic [CSR_DATA_WIDTH-1:0] csr_mtvec_i,
    input  logic [CSR_DATA_WIDTH-1:0] csr_mepc_i,
    output logic                      redirect_valid_o,
    output logic [CSR_DATA_WIDTH-1:0] redirect_pc_o
);

    localparam int unsigned AW = CSR_ADDR_WIDTH;
    localparam int unsigned DW = CSR_DATA_WIDTH;

    localparam logic [AW-1:0] ADDR_MSTATUS = AW'(12'h300);
    localparam logic [AW-1:0] ADDR_MEPC    = AW'(12'h341);
    localparam logic [AW-1:0] ADDR_MCAUSE  = AW'(12'h342);

    // MSTATUS field positions
    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;
    localparam int unsigned MPP_LO   = 11;
    localparam int unsigned MPP_HI   = 12;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_T_EPC   = 3'd1,
        S_T_CAUSE = 3'd2,
        S_T_STAT  = 3'd3,
        S_M_STAT  = 3'd4,
        S_REDIR   = 3'd5
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [DW-1:0]   trap_pc_q;
    logic [DW-1:0]   trap_cause_q;
    logic [DW-1:0]   mstatus_q;
    logic            is_trap_q;
    logic            trap_accept;
    logic            mret_accept;
    logic [DW-1:0]   redirect_target;

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M
    function automatic logic [DW-1:0] trap_mstatus(input logic [DW-1:0] s);
        logic [DW-1:0] r;
        r                 = s;
        r[MPIE_BIT]       = s[MIE_BIT];
        r[MIE_BIT]        = 1'b0;
        r[MPP_HI:MPP_LO]  = 2'b11;
        return r;
    endfunction

    // mret: MIE <= MPIE, MPIE <= 1, MPP stays M (M-mode only core)
    function automatic logic [DW-1:0] mret_mstatus(input logic [DW-1:0] s);
        logic [DW-1:0] r;
        r                 = s;
        r[MIE_BIT]        = s[MPIE_BIT];
        r[MPIE_BIT]       = 1'b1;
        r[MPP_HI:MPP_LO]  = 2'b11;
        return r;
    endfunction

    // Requests are only taken in IDLE; trap has priority, a concurrent mret stays pending
    assign trap_accept = (state_q == S_IDLE) && trap_valid_i;
    assign mret_accept = (state_q == S_IDLE) && mret_valid_i && !trap_valid_i;

    // Read data is a straight feed-through from the CSR file
    assign inst_csr_rdata_o = csr_rdata_i;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequence context: trap PC/cause at accept, MSTATUS snapshot while MEPC is written
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trap_pc_q    <= '0;
            trap_cause_q <= '0;
            mstatus_q    <= '0;
            is_trap_q    <= 1'b0;
        end else begin
            if (trap_accept) begin
                trap_pc_q    <= trap_pc_i;
                trap_cause_q <= trap_cause_i;
                is_trap_q    <= 1'b1;
            end else if (mret_accept) begin
                is_trap_q    <= 1'b0;
            end
            if (state_q == S_T_EPC) begin
                mstatus_q <= csr_rdata_i;
            end
        end
    end

    // Redirect target: MEPC for mret, MTVEC base (optionally vectored) for traps
`ifdef MTVEC_VECTORED_EN
    always_comb begin
        redirect_target = {csr_mtvec_i[DW-1:2], 2'b00};
        if (!is_trap_q) begin
            redirect_target = csr_mepc_i;
        end else if ((csr_mtvec_i[1:0] == 2'b01) && trap_cause_q[DW-1]) begin
            // cause << 2 wraps modulo 2^DW, so the top cause bit falls off
            redirect_target = {csr_mtvec_i[DW-1:2], 2'b00}
                            + {trap_cause_q[DW-3:0], 2'b00};
        end
    end
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^csr_mtvec_i[1:0];

    always_comb begin
        redirect_target = {csr_mtvec_i[DW-1:2], 2'b00};
        if (!is_trap_q) begin
            redirect_target = csr_mepc_i;
        end
    end
`endif

    // Next-state and CSR port ownership
    always_comb begin
        state_d          = state_q;
        busy_o           = 1'b1;
        csr_we_o         = 1'b0;
        csr_waddr_o      = '0;
        csr_wdata_o      = '0;
        csr_raddr_o      = ADDR_MSTATUS;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;

        case (state_q)
            S_IDLE: begin
                busy_o      = 1'b0;
                csr_we_o    = inst_csr_we_i;
                csr_waddr_o = inst_csr_waddr_i;
                csr_wdata_o = inst_csr_wdata_i;
                csr_raddr_o = inst_csr_raddr_i;
                if (trap_valid_i) begin
                    state_d = S_T_EPC;
                end else if (mret_valid_i) begin
                    state_d = S_M_STAT;
                end
            end
            S_T_EPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = trap_pc_q;
                state_d     = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = trap_cause_q;
                state_d     = S_T_STAT;
            end
            S_T_STAT: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = trap_mstatus(mstatus_q);
                state_d     = S_REDIR;
            end
            S_M_STAT: begin
                // Single-cycle read-modify-write through the combinational read port
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = mret_mstatus(csr_rdata_i);
                state_d     = S_REDIR;
            end
            S_REDIR: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = redirect_target;
                state_d          = S_IDLE;
            end
            default: begin
                busy_o  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Hold the CSR port and IFU quiet for as long as reset is asserted
        if (reset) begin
            busy_o           = 1'b0;
            csr_we_o         = 1'b0;
            csr_waddr_o      = '0;
            csr_wdata_o      = '0;
            redirect_valid_o = 1'b0;
            redirect_pc_o    = '0;
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: bench-owned CSR file, table vectors,
// hand-written multi-cycle corner cases and randomized traffic against a
// behavioural model of the architectural CSR effects.
module tb_csr_trap_ctrl;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    logic          clock;
    logic          reset;
    logic          inst_csr_we_i;
    logic [AW-1:0] inst_csr_waddr_i;
    logic [DW-1:0] inst_csr_wdata_i;
    logic [AW-1:0] inst_csr_raddr_i;
    logic [DW-1:0] inst_csr_rdata_o;
    logic          trap_valid_i;
    logic [DW-1:0] trap_cause_i;
    logic [DW-1:0] trap_pc_i;
    logic          mret_valid_i;
    logic          busy_o;
    logic          csr_we_o;
    logic [AW-1:0] csr_waddr_o;
    logic [DW-1:0] csr_wdata_o;
    logic [AW-1:0] csr_raddr_o;
    logic [DW-1:0] csr_rdata_i;
    logic [DW-1:0] csr_mtvec_i;
    logic [DW-1:0] csr_mepc_i;
    logic          redirect_valid_o;
    logic [DW-1:0] redirect_pc_o;

    int n_checks = 0;
    int n_pass   = 0;

    csr_trap_ctrl #(.CSR_ADDR_WIDTH(AW), .CSR_DATA_WIDTH(DW)) dut (
        .clock            (clock),
        .reset            (reset),
        .inst_csr_we_i    (inst_csr_we_i),
        .inst_csr_waddr_i (inst_csr_waddr_i),
        .inst_csr_wdata_i (inst_csr_wdata_i),
        .inst_csr_raddr_i (inst_csr_raddr_i),
        .inst_csr_rdata_o (inst_csr_rdata_o),
        .trap_valid_i     (trap_valid_i),
        .trap_cause_i     (trap_cause_i),
        .trap_pc_i        (trap_pc_i),
        .mret_valid_i     (mret_valid_i),
        .busy_o           (busy_o),
        .csr_we_o         (csr_we_o),
        .csr_waddr_o      (csr_waddr_o),
        .csr_wdata_o      (csr_wdata_o),
        .csr_raddr_o      (csr_raddr_o),
        .csr_rdata_i      (csr_rdata_i),
        .csr_mtvec_i      (csr_mtvec_i),
        .csr_mepc_i       (csr_mepc_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bench-side CSR file driven only by the DUT write port
    logic [DW-1:0] csr_mem [0:4095];
    always @(posedge clock) begin
        if (csr_we_o) csr_mem[csr_waddr_o] <= csr_wdata_o;
    end
    assign csr_rdata_i = csr_mem[csr_raddr_o];
    assign csr_mtvec_i = csr_mem[12'h305];
    assign csr_mepc_i  = csr_mem[12'h341];

    // Architectural model of the CSRs
    logic [DW-1:0] m_csr [logic [11:0]];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    function automatic logic [31:0] trap_status(input logic [31:0] m);
        return (m & ~32'h0000_0088) | ((m & 32'h0000_0008) << 4) | 32'h0000_1800;
    endfunction

    function automatic logic [31:0] mret_status(input logic [31:0] m);
        return (m & ~32'h0000_0008) | ((m & 32'h0000_0080) >> 4) | 32'h0000_1880;
    endfunction

    function automatic logic [31:0] trap_target(input logic [31:0] mtvec, input logic [31:0] cause);
        logic [31:0] t;
        t = mtvec & 32'hFFFF_FFFC;
`ifdef MTVEC_VECTORED_EN
        if (mtvec[1:0] == 2'b01 && cause[31]) t = t + ((cause & 32'h7FFF_FFFF) << 2);
`else
        if (cause[31] && 1'b0) t = 32'h0;
`endif
        return t;
    endfunction

    task automatic inst_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clock);
        inst_csr_we_i    = 1'b1;
        inst_csr_waddr_i = a;
        inst_csr_wdata_i = d;
        #1;
        check($sformatf("idle_pass_we_%03h", a), 32'(csr_we_o), 32'd1);
        @(negedge clock);
        inst_csr_we_i = 1'b0;
        #1;
        check($sformatf("idle_write_%03h", a), csr_mem[a], d);
        m_csr[a] = d;
    endtask

    task automatic rd_check(input logic [11:0] a);
        @(negedge clock);
        inst_csr_raddr_i = a;
        #1;
        check($sformatf("inst_rdata_%03h", a), inst_csr_rdata_o, m_csr[a]);
        inst_csr_raddr_i = '0;
    endtask

    task automatic run_trap(input logic [31:0] pc, input logic [31:0] cause, input bit inject,
                            output logic [31:0] red_pc);
        logic [31:0] exp_pc, exp_stat, old_mtvec;
        int red_n, red_k;
        logic busy5;
        exp_pc    = trap_target(m_csr[12'h305], cause);
        exp_stat  = trap_status(m_csr[12'h300]);
        old_mtvec = m_csr[12'h305];
        red_n = 0; red_k = 0; red_pc = '0; busy5 = 1'b1;
        @(negedge clock);
        trap_valid_i = 1'b1;
        trap_pc_i    = pc;
        trap_cause_i = cause;
        #1;
        check("trap_accept_not_busy", 32'(busy_o), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k == 1) trap_valid_i = 1'b0;
            if (inject && k == 2) begin
                inst_csr_we_i = 1'b1; inst_csr_waddr_i = 12'h305;
                inst_csr_wdata_i = 32'h123; inst_csr_raddr_i = 12'h305;
            end
            if (inject && k == 3) begin
                inst_csr_we_i = 1'b0; inst_csr_raddr_i = '0;
            end
            #1;
            if (inject && k == 2) begin
                check("busy_waddr_owned", 32'(csr_waddr_o), 32'h342);
                check("busy_raddr_not_fwd", 32'(csr_raddr_o != 12'h305), 32'd1);
            end
            if (redirect_valid_o) begin
                red_n++; red_k = k; red_pc = redirect_pc_o;
            end
            if (k == 5) busy5 = busy_o;
        end
        check("trap_redirect_count", 32'(red_n), 32'd1);
        check("trap_redirect_cycle", 32'(red_k), 32'd4);
        check("trap_redirect_pc", red_pc, exp_pc);
        check("trap_idle_n5", 32'(busy5), 32'd0);
        check("trap_mepc", csr_mem[12'h341], pc);
        check("trap_mcause", csr_mem[12'h342], cause);
        check("trap_mstatus", csr_mem[12'h300], exp_stat);
        if (inject) check("busy_mtvec_unchanged", csr_mem[12'h305], old_mtvec);
        m_csr[12'h341] = pc;
        m_csr[12'h342] = cause;
        m_csr[12'h300] = exp_stat;
    endtask

    task automatic run_mret(output logic [31:0] red_pc);
        logic [31:0] exp_pc, exp_stat;
        int red_n, red_k;
        logic busy3;
        exp_pc   = m_csr[12'h341];
        exp_stat = mret_status(m_csr[12'h300]);
        red_n = 0; red_k = 0; red_pc = '0; busy3 = 1'b1;
        @(negedge clock);
        mret_valid_i = 1'b1;
        #1;
        check("mret_accept_not_busy", 32'(busy_o), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            if (k == 1) mret_valid_i = 1'b0;
            #1;
            if (redirect_valid_o) begin
                red_n++; red_k = k; red_pc = redirect_pc_o;
            end
            if (k == 3) busy3 = busy_o;
        end
        check("mret_redirect_count", 32'(red_n), 32'd1);
        check("mret_redirect_cycle", 32'(red_k), 32'd2);
        check("mret_redirect_pc", red_pc, exp_pc);
        check("mret_idle_n3", 32'(busy3), 32'd0);
        check("mret_mstatus", csr_mem[12'h300], exp_stat);
        m_csr[12'h300] = exp_stat;
    endtask

    // trap and mret raised together: trap first, mret taken at N+5
    task automatic same_cycle();
        logic [31:0] p, c, exp_tpc, exp_stat, p1, p2;
        int n, k1, k2;
        p = 32'h8000_0600; c = 32'h5;
        exp_tpc  = trap_target(m_csr[12'h305], c);
        exp_stat = mret_status(trap_status(m_csr[12'h300]));
        n = 0; k1 = 0; k2 = 0; p1 = '0; p2 = '0;
        @(negedge clock);
        trap_valid_i = 1'b1; mret_valid_i = 1'b1; trap_pc_i = p; trap_cause_i = c;
        #1;
        check("sc_accept_not_busy", 32'(busy_o), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) trap_valid_i = 1'b0;
            if (k == 6) mret_valid_i = 1'b0;
            #1;
            if (k == 5) check("sc_idle_n5", 32'(busy_o), 32'd0);
            if (k == 6) check("sc_mret_busy_n6", 32'(busy_o), 32'd1);
            if (redirect_valid_o) begin
                n++;
                if (n == 1) begin k1 = k; p1 = redirect_pc_o; end
                else begin k2 = k; p2 = redirect_pc_o; end
            end
        end
        check("sc_redirect_count", 32'(n), 32'd2);
        check("sc_trap_redirect_cycle", 32'(k1), 32'd4);
        check("sc_trap_redirect_pc", p1, exp_tpc);
        check("sc_mret_redirect_cycle", 32'(k2), 32'd7);
        check("sc_mret_redirect_pc", p2, p);
        check("sc_mstatus", csr_mem[12'h300], exp_stat);
        check("sc_mcause", csr_mem[12'h342], c);
        m_csr[12'h341] = p; m_csr[12'h342] = c; m_csr[12'h300] = exp_stat;
    endtask

    // Reset while MCAUSE is being written: MEPC stays, nothing further, no redirect
    task automatic reset_mid();
        logic [31:0] p, c;
        int red_n;
        p = 32'h8000_0500; c = 32'h2; red_n = 0;
        @(negedge clock);
        trap_valid_i = 1'b1; trap_pc_i = p; trap_cause_i = c;
        @(negedge clock);
        trap_valid_i = 1'b0;
        @(negedge clock);
        #1;
        check("rm_tcause_we", 32'(csr_we_o), 32'd1);
        check("rm_tcause_waddr", 32'(csr_waddr_o), 32'h342);
        reset = 1'b1;
        #1;
        check("rm_we_low", 32'(csr_we_o), 32'd0);
        check("rm_busy_low", 32'(busy_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (k == 1) reset = 1'b0;
            #1;
            if (redirect_valid_o) red_n++;
        end
        check("rm_no_redirect", 32'(red_n), 32'd0);
        check("rm_idle_after", 32'(busy_o), 32'd0);
        check("rm_mepc_kept", csr_mem[12'h341], p);
        check("rm_mcause_untouched", csr_mem[12'h342], m_csr[12'h342]);
        check("rm_mstatus_untouched", csr_mem[12'h300], m_csr[12'h300]);
        m_csr[12'h341] = p;
    endtask

    typedef struct {
        bit          is_trap;
        logic [31:0] mstatus;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] exp_stat;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [31:0] rp;
        logic [11:0] addrs [5];
        logic [11:0] a;
        logic [31:0] d, c;

        addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341;
        addrs[3] = 12'h342; addrs[4] = 12'h340;

        tbl[0] = '{1'b1, 32'h0000_0008, 32'h8000_0100, 32'h0, 32'h8000_0010, 32'hB,
                   32'h0000_1880, 32'h8000_0100};
        tbl[1] = '{1'b0, 32'h0000_1880, 32'h8000_0100, 32'h8000_0014, 32'h0, 32'h0,
                   32'h0000_1888, 32'h8000_0014};
`ifdef MTVEC_VECTORED_EN
        tbl[2] = '{1'b1, 32'h0000_1888, 32'h8000_0001, 32'h0, 32'h8000_0200, 32'h8000_0007,
                   32'h0000_1880, 32'h8000_001C};
`else
        tbl[2] = '{1'b1, 32'h0000_1888, 32'h8000_0001, 32'h0, 32'h8000_0200, 32'h8000_0007,
                   32'h0000_1880, 32'h8000_0000};
`endif
        tbl[3] = '{1'b0, 32'h0000_0000, 32'h0, 32'h0000_1234, 32'h0, 32'h0,
                   32'h0000_1880, 32'h0000_1234};
        tbl[4] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0FFF, 32'h0, 32'h0000_0044, 32'h8000_0003,
                   32'hFFFF_FFF7, 32'h0000_0FFC};
        tbl[5] = '{1'b0, 32'hFFFF_FF77, 32'h0, 32'h0000_0ABC, 32'h0, 32'h0,
                   32'hFFFF_FFF7, 32'h0000_0ABC};

        reset = 1'b1;
        inst_csr_we_i = 1'b1; inst_csr_waddr_i = 12'h305; inst_csr_wdata_i = 32'hDEAD_BEEF;
        inst_csr_raddr_i = '0; trap_valid_i = 1'b0; trap_cause_i = '0; trap_pc_i = '0;
        mret_valid_i = 1'b0;
        #1;
        check("reset_we", 32'(csr_we_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_redirect_valid", 32'(redirect_valid_o), 32'd0);
        check("reset_redirect_pc", redirect_pc_o, 32'd0);
        repeat (2) @(negedge clock);
        inst_csr_we_i = 1'b0;
        reset = 1'b0;

        foreach (addrs[i]) inst_write(addrs[i], 32'h0);

        for (int i = 0; i < 6; i++) begin
            inst_write(12'h300, tbl[i].mstatus);
            inst_write(12'h305, tbl[i].mtvec);
            inst_write(12'h341, tbl[i].mepc);
            if (tbl[i].is_trap) run_trap(tbl[i].pc, tbl[i].cause, 1'b0, rp);
            else run_mret(rp);
            check($sformatf("tbl%0d_pc", i), rp, tbl[i].exp_pc);
            check($sformatf("tbl%0d_mstatus", i), csr_mem[12'h300], tbl[i].exp_stat);
        end

        inst_write(12'h300, 32'h0000_0008);
        inst_write(12'h305, 32'h8000_0100);
        same_cycle();
        reset_mid();
        run_trap(32'h8000_0700, 32'h3, 1'b1, rp);
        inst_write(12'h305, 32'h123);
        rd_check(12'h341);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = addrs[$urandom_range(0, 4)];
                    d = $urandom;
                    if (a == 12'h305 && $urandom_range(0, 1) == 1) d[1:0] = 2'b01;
                    inst_write(a, d);
                end
                1: begin
                    c = $urandom;
                    if ($urandom_range(0, 1) == 1) c[30:0] = 31'($urandom_range(0, 31));
                    run_trap($urandom, c, 1'b0, rp);
                end
                2: run_mret(rp);
                default: rd_check(addrs[$urandom_range(0, 4)]);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
